// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO UART transmitter.
// Register map offsets, STATUS bit positions and TX FSM state encoding.
package mmio_pkg;

  localparam logic [31:0] UART_BASE  = 32'hFFFF_FFE0;
  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int ST_ACTIVE    = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// byte_fifo: circular FIFO with push/pop, full/empty flags and occupancy count.
// Ports: clk, reset (sync, active-high), push/push_data, pop/pop_data, full, empty, count.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             pop_ok;
  logic             push_ok;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        cnt <= cnt + CW'(1);
      end else if (pop_ok && !push_ok) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores queue bytes, STATUS loads report state.
// Ports: clk, reset, store bus (write_mem/funct3/write_address/write_data), load bus
// (read_address -> read_data/read_hit, 1-cycle latency), serial tx, busy.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = UART_BASE,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        read_hit,
  output logic        tx,
  output logic        busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] TX_ADDR = BASE_ADDR + TXDATA_OFS;
  localparam logic [31:0] ST_ADDR = BASE_ADDR + STATUS_OFS;

  tx_state_t     state, state_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_q, tx_n;
  logic          ovf;
  logic          pop;
  logic          wrap;

  logic          width_ok;
  logic          st_tx;
  logic          st_stat;
  logic          rd_tx;
  logic          rd_stat;

  logic [7:0]    fifo_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   count32;
  logic [31:0]   status;
  logic          unused_ok;

  assign unused_ok = ^write_data[31:8];

  assign width_ok = (funct3 == 3'b000) ||
                    (funct3 == 3'b001) ||
                    (funct3 == 3'b010);
  assign st_tx    = write_mem && width_ok &&
                    (write_address == TX_ADDR);
  assign st_stat  = write_mem && width_ok &&
                    (write_address == ST_ADDR);
  assign rd_tx    = (read_address == TX_ADDR);
  assign rd_stat  = (read_address == ST_ADDR);

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (st_tx),
    .push_data (write_data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_q),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign count32 = 32'(fifo_count);

  always_comb begin
    status = '0;
    status[ST_ACTIVE] = (state != TX_IDLE);
    status[ST_FULL]   = fifo_full;
    status[ST_EMPTY]  = fifo_empty;
    status[ST_OVF]    = ovf;
    status[ST_COUNT_LSB +: 8] = sat8(count32);
  end

  assign busy = (state != TX_IDLE) || !fifo_empty;
  assign tx   = tx_q;
  assign wrap = (bcnt == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n   = state;
    bcnt_n    = bcnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    unique case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_q;
          bcnt_n  = '0;
          state_n = TX_START;
        end
      end
      TX_START: begin
        if (wrap) begin
          bcnt_n    = '0;
          bit_idx_n = '0;
          state_n   = TX_DATA;
        end else begin
          bcnt_n = bcnt + BW'(1);
        end
      end
      TX_DATA: begin
        if (wrap) begin
          bcnt_n  = '0;
          shift_n = shift >> 1;
          if (bit_idx == 3'd7) begin
            state_n = TX_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          bcnt_n = bcnt + BW'(1);
        end
      end
      TX_STOP: begin
        if (wrap) begin
          bcnt_n = '0;
          // Chain straight into the next start bit to keep frames contiguous.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_q;
            state_n = TX_START;
          end else begin
            state_n = TX_IDLE;
          end
        end else begin
          bcnt_n = bcnt + BW'(1);
        end
      end
      default: begin
        state_n = TX_IDLE;
      end
    endcase
  end

  // Line level is precomputed from next state so tx is a plain flop output.
  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      TX_START: tx_n = 1'b0;
      TX_DATA:  tx_n = shift_n[0];
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= TX_IDLE;
      bcnt      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      tx_q      <= 1'b1;
      ovf       <= 1'b0;
      read_data <= '0;
      read_hit  <= 1'b0;
    end else begin
      state     <= state_n;
      bcnt      <= bcnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      tx_q      <= tx_n;
      if (st_tx && fifo_full && !pop) begin
        ovf <= 1'b1;
      end else if (st_stat && write_data[3]) begin
        ovf <= 1'b0;
      end
      read_hit  <= rd_stat || rd_tx;
      read_data <= rd_stat ? status : 32'h0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx.
// Uses CLKS_PER_BIT=4, FIFO_DEPTH=4; drives and samples on the falling edge.
module tb_mmio_uart_tx;

  localparam logic [31:0] TXA = 32'hFFFF_FFE0;
  localparam logic [31:0] STA = 32'hFFFF_FFE4;

  logic        clk;
  logic        reset;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        read_hit;
  logic        tx;
  logic        busy;

  int total;
  int bad;

  mmio_uart_tx #(
    .BASE_ADDR    (32'hFFFF_FFE0),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .write_mem     (write_mem),
    .funct3        (funct3),
    .write_address (write_address),
    .write_data    (write_data),
    .read_address  (read_address),
    .read_data     (read_data),
    .read_hit      (read_hit),
    .tx            (tx),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [2:0]  f);
    write_mem     = 1'b1;
    write_address = a;
    write_data    = d;
    funct3        = f;
    @(negedge clk);
    write_mem     = 1'b0;
  endtask

  task automatic load_chk(input string tag,
                          input logic [31:0] a,
                          input logic        exp_hit,
                          input logic [31:0] exp_data);
    read_address = a;
    @(negedge clk);
    chk({tag, "_hit"}, 32'(read_hit), 32'(exp_hit));
    chk({tag, "_data"}, read_data, exp_data);
    read_address = 32'h0;
  endtask

  // Called one cycle after the byte became visible to the FSM (IDLE cycle).
  task automatic expect_frame(input logic [7:0] b);
    logic e;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 4) e = 1'b0;
      else if (i < 36) e = b[(i - 4) / 4];
      else e = 1'b1;
      chk($sformatf("frame_%h_c%0d", b, i), 32'(tx), 32'(e));
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 500), 32'd1);
  endtask

  initial begin
    int lows;
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    write_mem     = 1'b0;
    funct3        = 3'b000;
    write_address = 32'h0;
    write_data    = 32'h0;
    read_address  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_hit", 32'(read_hit), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single sb frame
    store(TXA, 32'h0000_00A5, 3'b000);
    chk("t1_idle_tx", 32'(tx), 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'd1);
    expect_frame(8'hA5);
    chk("t1_stop_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_done_busy", 32'(busy), 32'd0);
    chk("t1_done_tx", 32'(tx), 32'd1);
    repeat (3) @(negedge clk);

    // back-to-back frames, mixed store widths
    fork
      begin
        store(TXA, 32'h0000_0001, 3'b000);
        store(TXA, 32'hABCD_0002, 3'b001);
        store(TXA, 32'h1234_5603, 3'b010);
      end
      begin
        @(negedge clk);
        expect_frame(8'h01);
        expect_frame(8'h02);
        expect_frame(8'h03);
      end
    join
    @(negedge clk);
    chk("t2_done_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // overflow: 1 popped + 4 queued + 1 dropped
    for (int i = 0; i < 6; i++) begin
      store(TXA, 32'(8'h10 + i), 3'b000);
    end
    load_chk("t3_ovf", STA, 1'b1, 32'h0000_040B);
    store(STA, 32'h0000_0008, 3'b010);
    load_chk("t3_clr", STA, 1'b1, 32'h0000_0403);
    wait_idle("t3_drain");

    // loads
    @(negedge clk);
    load_chk("t4_stat", STA, 1'b1, 32'h0000_0004);
    load_chk("t4_miss", 32'h0000_0100, 1'b0, 32'h0);
    load_chk("t4_txd", TXA, 1'b1, 32'h0);

    // reset mid-frame with two bytes queued
    store(TXA, 32'h0000_0037, 3'b000);
    store(TXA, 32'h0000_0055, 3'b000);
    store(TXA, 32'h0000_0066, 3'b000);
    repeat (16) @(negedge clk);
    chk("t5_bit3", 32'(tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_rst_tx", 32'(tx), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    load_chk("t5_stat", STA, 1'b1, 32'h0000_0004);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("t5_quiet", 32'(lows), 32'd0);

    // ignored stores
    store(TXA, 32'h0000_0077, 3'b100);
    store(32'hFFFF_FFE1, 32'h0000_0077, 3'b010);
    chk("t6_busy", 32'(busy), 32'd0);
    load_chk("t6_stat", STA, 1'b1, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
